// File: rtl/video_timing_pkg.sv
// Shared 720p60 raster constants so the timing generator, ray tracer and
// encoder all agree on frame geometry and pixel-coordinate width.
package video_timing_pkg;

    localparam int H_ACTIVE = 1280;
    localparam int H_FRONT  = 110;
    localparam int H_SYNC   = 40;
    localparam int H_BACK   = 220;
    localparam int V_ACTIVE = 720;
    localparam int V_FRONT  = 5;
    localparam int V_SYNC   = 5;
    localparam int V_BACK   = 20;

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam int CNT_W = 11;

    typedef logic [CNT_W-1:0] coord_t;

endpackage

// File: rtl/sync_window_decode.sv
// Inclusive window compare: flags when value lies within [LO, HI].
module sync_window_decode #(
    parameter int          W  = 11,
    parameter logic [W-1:0] LO = 1,
    parameter logic [W-1:0] HI = 1
) (
    input  logic [W-1:0] value,
    output logic         in_window
);

    assign in_window = (value >= LO) && (value <= HI);

endmodule

// File: rtl/video_timing_generator.sv
// Free-running raster counter with zero-latency sync/active decode; the
// syncs and active flag are combinationally forced inactive during reset.
module video_timing_generator #(
    parameter int   H_ACTIVE  = video_timing_pkg::H_ACTIVE,
    parameter int   H_FRONT   = video_timing_pkg::H_FRONT,
    parameter int   H_SYNC    = video_timing_pkg::H_SYNC,
    parameter int   H_BACK    = video_timing_pkg::H_BACK,
    parameter int   V_ACTIVE  = video_timing_pkg::V_ACTIVE,
    parameter int   V_FRONT   = video_timing_pkg::V_FRONT,
    parameter int   V_SYNC    = video_timing_pkg::V_SYNC,
    parameter int   V_BACK    = video_timing_pkg::V_BACK,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1,
    parameter int   CNT_W     = video_timing_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             video_active
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             h_in_sync;
    logic             v_in_sync;

    always_comb begin
        hcount_d = hcount_q + 1'b1;
        vcount_d = vcount_q;
        if (reset) begin
            hcount_d = '0;
            vcount_d = '0;
        end else if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        hcount_q <= hcount_d;
        vcount_q <= vcount_d;
    end

    sync_window_decode #(.W(CNT_W), .LO(HS_LO), .HI(HS_HI)) u_hsync_win (
        .value     (hcount_q),
        .in_window (h_in_sync)
    );

    sync_window_decode #(.W(CNT_W), .LO(VS_LO), .HI(VS_HI)) u_vsync_win (
        .value     (vcount_q),
        .in_window (v_in_sync)
    );

    // vsync decodes from vcount only, so it can only change where vcount does: at hcount wrap.
    assign hcount       = hcount_q;
    assign vcount       = vcount_q;
    assign hsync        = (h_in_sync && !reset) ? HSYNC_POL : ~HSYNC_POL;
    assign vsync        = (v_in_sync && !reset) ? VSYNC_POL : ~VSYNC_POL;
    assign video_active = (hcount_q < H_VIS) && (vcount_q < V_VIS) && !reset;

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator: a full-size 720p instance for line timing
// and a shrunken-geometry instance for frame-level behaviour and random resets.
module tb_video_timing_generator;

    // Shrunken geometry: H total 28 (sync 20..22), V total 13 (sync 8..9).
    localparam int S_HA = 16, S_HF = 4, S_HS = 3, S_HB = 5;
    localparam int S_VA = 6,  S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_FRAME  = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);
    localparam int S_ACTIVE = S_HA * S_VA;

    logic        clk;
    logic        rst_l, rst_s;
    logic [10:0] hcount_l, vcount_l, hcount_s, vcount_s;
    logic        hsync_l, vsync_l, va_l, hsync_s, vsync_s, va_s;

    int n_checks;
    int n_fail;
    int n_l, n_s;
    logic chk_en;

    typedef struct {
        int   cyc;
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic va;
    } vec_t;

    vec_t tbl[12];

    video_timing_generator dut_l (
        .clk          (clk),
        .reset        (rst_l),
        .hcount       (hcount_l),
        .vcount       (vcount_l),
        .hsync        (hsync_l),
        .vsync        (vsync_l),
        .video_active (va_l)
    );

    video_timing_generator #(
        .H_ACTIVE (S_HA), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_ACTIVE (S_VA), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
    ) dut_s (
        .clk          (clk),
        .reset        (rst_s),
        .hcount       (hcount_s),
        .vcount       (vcount_s),
        .hsync        (hsync_s),
        .vsync        (vsync_s),
        .video_active (va_s)
    );

    // Clock and reset-free model time base.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_l = 0;
        n_s = 0;
        forever begin
            @(posedge clk);
            n_l = rst_l ? 0 : n_l + 1;
            n_s = rst_s ? 0 : n_s + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference: position is simply cycles-since-reset folded by the frame geometry.
    task automatic check_all(input string tag, input int n, input logic rst,
                             input int ha, input int hf, input int hs, input int hb,
                             input int va, input int vf, input int vs, input int vb,
                             input logic [10:0] h_act, input logic [10:0] v_act,
                             input logic hs_act, input logic vs_act, input logic va_act);
        int ht, vt, h, v;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        h  = n % ht;
        v  = (n / ht) % vt;
        chk({tag, ".hcount"}, h_act, h);
        chk({tag, ".vcount"}, v_act, v);
        chk({tag, ".hsync"}, hs_act, (!rst && h >= ha + hf && h < ha + hf + hs));
        chk({tag, ".vsync"}, vs_act, (!rst && v >= va + vf && v < va + vf + vs));
        chk({tag, ".video_active"}, va_act, (!rst && h < ha && v < va));
    endtask

    // Every-cycle model comparison plus pulse-width / frame-period tracking.
    initial begin
        logic prev_hs_l, hs_ok, prev_vs_s, have_rise;
        int   hs_run, period, act_cnt;
        prev_hs_l = 1'b0; hs_ok = 1'b0; hs_run = 0;
        prev_vs_s = 1'b0; have_rise = 1'b0; period = 0; act_cnt = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check_all("run_l", n_l, rst_l, 1280, 110, 40, 220, 720, 5, 5, 20,
                          hcount_l, vcount_l, hsync_l, vsync_l, va_l);
                check_all("run_s", n_s, rst_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB,
                          hcount_s, vcount_s, hsync_s, vsync_s, va_s);

                if (rst_l) begin
                    hs_ok  = 1'b0;
                    hs_run = 0;
                end else if (hsync_l) begin
                    if (!prev_hs_l) begin
                        hs_ok  = 1'b1;
                        hs_run = 1;
                    end else begin
                        hs_run++;
                    end
                end else if (prev_hs_l && hs_ok) begin
                    chk("hsync_width", hs_run, 40);
                end
                prev_hs_l = hsync_l;

                if (rst_s) begin
                    have_rise = 1'b0;
                end else begin
                    if (vsync_s && !prev_vs_s) begin
                        if (have_rise) begin
                            chk("frame_period", period, S_FRAME);
                            chk("frame_active", act_cnt, S_ACTIVE);
                        end
                        have_rise = 1'b1;
                        period    = 0;
                        act_cnt   = 0;
                    end
                    period++;
                    act_cnt += int'(va_s);
                end
                prev_vs_s = vsync_s;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        rst_l    = 1'b1;
        rst_s    = 1'b1;

        tbl[0]  = '{0,    0,    0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1279, 1279, 0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1280, 1280, 0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1389, 1389, 0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1390, 1390, 0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1429, 1429, 0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1430, 1430, 0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1649, 1649, 0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1650, 0,    1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1651, 1,    1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{4579, 1279, 2, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{4580, 1280, 2, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst_l = 1'b0;
        rst_s = 1'b0;

        // Table-driven line timing on the full-size instance.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            while (n_l < tbl[i].cyc) @(negedge clk);
            chk($sformatf("tbl%0d.hcount", i), hcount_l, tbl[i].h);
            chk($sformatf("tbl%0d.vcount", i), vcount_l, tbl[i].v);
            chk($sformatf("tbl%0d.hsync", i), hsync_l, tbl[i].hs);
            chk($sformatf("tbl%0d.vsync", i), vsync_l, tbl[i].vs);
            chk($sformatf("tbl%0d.video_active", i), va_l, tbl[i].va);
        end

        // Frame wrap on the small instance: last pixel then (0,0) active.
        @(negedge clk);
        while (n_s % S_FRAME != S_FRAME - 1) @(negedge clk);
        chk("wrap.last_h", hcount_s, 27);
        chk("wrap.last_v", vcount_s, 12);
        @(negedge clk);
        chk("wrap.first_h", hcount_s, 0);
        chk("wrap.first_v", vcount_s, 0);
        chk("wrap.first_active", va_s, 1);

        // One-cycle reset mid-frame at (11,5).
        @(negedge clk);
        while (n_s % S_FRAME != 5 * 28 + 10) @(negedge clk);
        chk("midrst.pre_h", hcount_s, 10);
        chk("midrst.pre_v", vcount_s, 5);
        @(posedge clk);
        #1 rst_s = 1'b1;
        @(negedge clk);
        chk("midrst.hold_h", hcount_s, 11);
        chk("midrst.hold_active", va_s, 0);
        @(posedge clk);
        #1 rst_s = 1'b0;
        @(negedge clk);
        chk("midrst.post_h", hcount_s, 0);
        chk("midrst.post_v", vcount_s, 0);
        chk("midrst.post_active", va_s, 1);
        chk("midrst.post_hsync", hsync_s, 0);
        chk("midrst.post_vsync", vsync_s, 0);

        // Random reset pulses of random length at random positions.
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(1, 900)) @(posedge clk);
            #1;
            rst_s = 1'b1;
            rst_l = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            rst_s = 1'b0;
            rst_l = 1'b0;
        end
        repeat (2 * S_FRAME) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_generator.md
Name: video_timing_generator

Overview:
- Free-running raster timing generator for 1280x720p60 (74.25 MHz pixel clock, 1650 x 750 total).
- Produces horizontal and vertical pixel counters, hsync, vsync and a video_active qualifier.
- Sits at the head of the display pipeline; the pixel generator (ray tracer) and the HDMI/VGA encoder consume its outputs.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FRONT, 110, horizontal front porch in pixels
- H_SYNC, 40, hsync pulse width in pixels
- H_BACK, 220, horizontal back porch in pixels
- V_ACTIVE, 720, visible lines per frame
- V_FRONT, 5, vertical front porch in lines
- V_SYNC, 5, vsync pulse width in lines
- V_BACK, 20, vertical back porch in lines
- HSYNC_POL, 1, level driven on hsync during the sync pulse (1 = active-high)
- VSYNC_POL, 1, level driven on vsync during the sync pulse (1 = active-high)
- CNT_W, 11, counter width; must hold H_TOTAL-1 (1649) and V_TOTAL-1 (749)

Ports:
- clk  in  1  pixel clock, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- hcount  out  CNT_W  current pixel column, 0..H_TOTAL-1
- vcount  out  CNT_W  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_active  out  1  high while the current pixel is visible

Interface constraint (already decided): one clock, clk; reset is synchronous and active-high.

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK (1650).
  - V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK (750).
- Counter registers:
  - hcount and vcount are registers; all other outputs are decoded from the current register values.
  - Every output is therefore valid in the same cycle as the counts it describes, with zero decode latency.
- On a clk edge with reset=1: hcount <= 0, vcount <= 0.
- While reset=1, hsync = ~HSYNC_POL, vsync = ~VSYNC_POL and video_active = 0. This is a combinational gate on reset.
- On a clk edge with reset=0:
  - If hcount == H_TOTAL-1: hcount <= 0.
    - If vcount == V_TOTAL-1: vcount <= 0.
    - Otherwise: vcount <= vcount+1.
  - Otherwise: hcount <= hcount+1 and vcount holds.
- hsync = HSYNC_POL when H_ACTIVE+H_FRONT <= hcount < H_ACTIVE+H_FRONT+H_SYNC, i.e. 1390..1429 inclusive; otherwise ~HSYNC_POL.
- vsync = VSYNC_POL when V_ACTIVE+V_FRONT <= vcount < V_ACTIVE+V_FRONT+V_SYNC, i.e. 725..729 inclusive; otherwise ~VSYNC_POL.
  - vsync transitions only at line boundaries, coincident with hcount == 0.
- video_active = (hcount < H_ACTIVE) && (vcount < V_ACTIVE) && !reset.
- Wrap-around: the last pixel is (1649,749); the next cycle is (0,0), and video_active rises again immediately.
- Reset mid-frame:
  - The next edge forces (0,0) and the outputs go inactive while reset is held.
  - After release, the first cycle shows (0,0) with video_active=1 and both syncs inactive.
- No enable input; the counters advance every cycle when not in reset.
- Frame period is exactly 1,237,500 clocks.

Decomposition:
- Shared package video_timing_pkg holds:
  - the 720p timing constants (H/V active, front, sync, back);
  - the derived H_TOTAL and V_TOTAL;
  - the counter width, so consumers (ray tracer, encoder) size their pixel coordinates identically.
- A single module is sufficient. An optional sub-module sync_window_decode (lo/hi compare producing an in-window flag) may be instantiated twice, once for hsync and once for vsync.

Test Plan:
- Reset held 10 cycles -> hcount=0, vcount=0, hsync=0, vsync=0, video_active=0 throughout. First cycle after release: (0,0), video_active=1.
- Free-run one line:
  - hcount counts 0..1649 then returns to 0, and vcount increments 0 -> 1 at that wrap.
  - video_active is 1 for hcount 0..1279 and 0 from 1280.
- Hsync window:
  - hsync=0 at hcount 1389, 1 at 1390 and 1429, 0 at 1430.
  - The pulse is exactly 40 clocks high every line.
- Vsync window:
  - vsync=0 on line 724, 1 from (0,725) through (1649,729), 0 at (0,730).
  - video_active stays 0 on all lines 720..749.
- Frame wrap over 2 full frames:
  - (1649,749) -> (0,0).
  - Exactly 1,237,500 clocks between successive vsync rising edges.
  - 921,600 active cycles per frame.
- Reset asserted at (800,300) for 1 cycle -> next cycle (0,0), outputs inactive during reset, normal counting resumes from (0,0).
